// File: rtl/pipe_reg_chain_pkg.sv
// pipe_pkg: shared constants and helpers for the pipe_reg_chain register pipeline.
package pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// pipe_stage: one register slice of the pipeline; data only loads on a valid source word.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             move,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             v,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            v    <= 1'b0;
            data <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (move) begin
            v <= src_valid;
            if (src_valid) data <= src_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register pipeline with bubble collapsing.
// Define PIPE_REG_CHAIN_OCCUPANCY_EN to add the occupancy counter output.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    output logic [WIDTH-1:0]            out_data,
    output logic [occ_width(DEPTH)-1:0] occupancy
`else
    output logic [WIDTH-1:0]            out_data
`endif
);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] data;
    } stage_t;

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] mv;
    logic [WIDTH-1:0] data [DEPTH];
    stage_t           src  [DEPTH];
    logic             down;

    // Walk from the output back: a stage moves if it is empty or its word leaves.
    always_comb begin
        down = out_ready;
        adv  = '0;
        mv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = v[i] & down;
            mv[i]  = ~v[i] | adv[i];
            down   = mv[i];
        end
    end

    assign in_ready = mv[0] & ~flush;

    always_comb begin
        src[0] = '{v: in_valid & in_ready, data: in_data};
        for (int i = 1; i < DEPTH; i++) src[i] = '{v: v[i-1], data: data[i-1]};
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .move      (mv[i]),
            .src_valid (src[i].v),
            .src_data  (src[i].data),
            .v         (v[i]),
            .data      (data[i])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = data[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    logic push, pop;
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) occupancy <= '0;
        else occupancy <= (push && !pop) ? occupancy + 1'b1 :
                          (pop && !push) ? occupancy - 1'b1 : occupancy;
    end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed plan scenarios plus random traffic against a position-queue model.
module tb_pipe_reg_chain;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 0;
    logic             rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
    logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

    pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
        .out_data  (out_data),
        .occupancy (occupancy)
`else
        .out_data  (out_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int qd[$];
    int qp[$];
    bit data_zero = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Words in flight, oldest first, each with its stage position.
    // A word steps forward by one but never onto or past the word ahead of it.
    function automatic void advance(inout int p[$]);
        for (int k = 0; k < p.size(); k++) begin
            int lim = (k == 0) ? DEPTH - 1 : p[k-1] - 1;
            p[k] = (p[k] + 1 < lim) ? p[k] + 1 : lim;
        end
    endfunction

    function automatic int tail_after(input bit pop);
        int p[$] = qp;
        if (pop) void'(p.pop_front());
        advance(p);
        return p.size() == 0 ? -1 : p[p.size()-1];
    endfunction

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [WIDTH-1:0] d, input logic ordy);
        bit eov, eir;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        eov = qd.size() > 0 && qp[0] == DEPTH - 1;
        eir = !f && tail_after(eov && ordy) != 0;
        check("out_valid", out_valid, eov);
        if (eov) check("out_data", out_data, qd[0]);
        if (data_zero) check("out_data_zero", out_data, 0);
        check("in_ready", in_ready, eir);
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
        check("occupancy", occupancy, qd.size());
`endif
        @(posedge clk);
        if (r) begin
            qd.delete(); qp.delete(); data_zero = 1;
        end else if (f) begin
            qd.delete(); qp.delete();
        end else begin
            if (eov && ordy) begin
                void'(qd.pop_front()); void'(qp.pop_front());
            end
            advance(qp);
            if (iv && eir) begin
                qd.push_back(d); qp.push_back(0); data_zero = 0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 8'h00, 1);
    endtask

    initial begin
        // reset with upstream active
        step(1, 0, 1, 8'hAA, 1);
        step(1, 0, 1, 8'hAA, 1);
        step(0, 0, 0, 8'h00, 1);
        // streaming at full rate
        for (int i = 1; i <= 10; i++) step(0, 0, 1, WIDTH'(i), 1);
        drain();
        // fill while stalled, then pop and push together
        step(0, 0, 1, 8'h11, 0);
        step(0, 0, 1, 8'h22, 0);
        step(0, 0, 1, 8'h33, 0);
        step(0, 0, 1, 8'h44, 0);
        step(0, 0, 1, 8'h44, 1);
        drain();
        // bubbles with toggling out_ready
        step(0, 0, 1, 8'hA1, 0);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'hA2, 0);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'hA3, 0);
        step(0, 0, 1, 8'hA4, 0);
        step(0, 0, 1, 8'hA5, 0);
        step(0, 0, 1, 8'hA6, 0);
        drain();
        // flush a full pipe, then refill
        step(0, 0, 1, 8'h61, 0);
        step(0, 0, 1, 8'h62, 0);
        step(0, 0, 1, 8'h63, 0);
        step(0, 1, 1, 8'h64, 1);
        step(0, 0, 1, 8'h5A, 1);
        drain();
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            int rr = $urandom_range(0, 199);
            step(rr == 0, rr inside {[1:4]}, $urandom_range(0, 9) < 7,
                 WIDTH'($urandom), $urandom_range(0, 1));
        end
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
